// File: rtl/partition_pkg.sv
// Shared types and sizing helpers for the partition sweep controller.
package partition_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_e;

    localparam int DEF_PI_W = 6;
    localparam int DEF_PO_W = 4;

    // hd_sum can reach 2^pi_w * po_w, so it needs pi_w plus the popcount width.
    function automatic int hd_sum_w(input int pi_w, input int po_w);
        return pi_w + $clog2(po_w + 1);
    endfunction

endpackage

// File: rtl/popcount.sv
// Combinational Hamming weight of a PO_W-bit vector.
module popcount #(
    parameter int PO_W = 4
) (
    input  logic [PO_W-1:0]            vec_i,
    output logic [$clog2(PO_W+1)-1:0]  cnt_o
);

    localparam int CW = $clog2(PO_W + 1);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < PO_W; i++) begin
            cnt_o = cnt_o + CW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/partition_sweep_ctrl.sv
// Sweeps every input pattern into an exact and an approximate partition and
// accumulates mismatch count, Hamming-distance sum and worst-case error.
module partition_sweep_ctrl
    import partition_pkg::*;
#(
    parameter int PI_W   = DEF_PI_W,
    parameter int PO_W   = DEF_PO_W,
    parameter int SETTLE = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [PO_W-1:0]                   po_exact,
    input  logic [PO_W-1:0]                   po_apx,
    output logic [PI_W-1:0]                   pi,
    output logic                              busy,
    output logic                              done,
    output logic [PI_W:0]                     err_cnt,
    output logic [hd_sum_w(PI_W, PO_W)-1:0]   hd_sum,
    output logic [PO_W-1:0]                   wce
);

    localparam int ERR_W = PI_W + 1;
    localparam int HD_W  = hd_sum_w(PI_W, PO_W);
    localparam int PC_W  = $clog2(PO_W + 1);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e             state_q, state_d;
    logic [PI_W-1:0]    pi_q, pi_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [HD_W-1:0]    hd_q, hd_d;
    logic [PO_W-1:0]    wce_q, wce_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [PO_W-1:0]    diff_bits;
    logic [PC_W-1:0]    diff_pc;
    logic [PO_W-1:0]    abs_diff;

    assign diff_bits = po_apx ^ po_exact;

    popcount #(.PO_W(PO_W)) u_popcount (
        .vec_i (diff_bits),
        .cnt_o (diff_pc)
    );

    always_comb begin
        abs_diff = (po_apx > po_exact) ? (po_apx - po_exact) : (po_exact - po_apx);
    end

    always_comb begin
        state_d = state_q;
        pi_d    = pi_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        hd_d    = hd_q;
        wce_d   = wce_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    pi_d    = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    hd_d    = '0;
                    wce_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                // An abort here drops this pattern's contribution entirely.
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (diff_bits != '0) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    hd_d = hd_q + HD_W'(diff_pc);
                    if (abs_diff > wce_q) begin
                        wce_d = abs_diff;
                    end
                    if (pi_q == '1) begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        pi_d    = pi_q + PI_W'(1);
                        state_d = DRIVE;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pi_q    <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            hd_q    <= '0;
            wce_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pi_q    <= pi_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            hd_q    <= hd_d;
            wce_q   <= wce_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pi      = pi_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err_cnt = err_q;
    assign hd_sum  = hd_q;
    assign wce     = wce_q;

endmodule

// File: doc/partition_sweep_ctrl.md
PARTITION_SWEEP_CTRL -- requirements
Module: partition_sweep_ctrl

Interface
REQ-001 Parameters SHALL be:
- PI_W, default 6: partition input width.
- PO_W, default 4: partition output width.
- SETTLE, default 1, legal >=1: cycles each pattern is held before sampling.
REQ-002 clk  input  1: single clock; all state updates on its rising edge.
REQ-003 rst  input  1: synchronous, active-high reset.
REQ-004 start  input  1: request a sweep; accepted only in IDLE.
REQ-005 abort  input  1: terminate a running sweep.
REQ-006 po_exact  input  PO_W: output of the exact partition for the current pi.
REQ-007 po_apx  input  PO_W: output of the approximate partition for the current pi.
REQ-008 pi  output  PI_W: registered input pattern driven to both partitions.
REQ-009 busy  output  1: high from start acceptance until the sweep completes or is aborted.
REQ-010 done  output  1: one-cycle pulse when a complete sweep finishes.
REQ-011 err_cnt  output  PI_W+1: number of patterns with po_apx != po_exact.
REQ-012 hd_sum  output  PI_W+$clog2(PO_W+1): sum of popcount(po_apx ^ po_exact) over all patterns.
REQ-013 wce  output  PO_W: maximum of |po_apx - po_exact| (both unsigned) over all patterns.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, DRIVE, SAMPLE, FIN.
REQ-015 In IDLE with start=1, the block SHALL do all of the following at the next edge:
- enter DRIVE;
- set pi=0;
- clear err_cnt, hd_sum and wce;
- set busy=1.
REQ-016 DRIVE SHALL last exactly SETTLE cycles, counted by a settle counter, and then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle and use the po_exact/po_apx values present in that cycle.
REQ-018 In SAMPLE, a mismatch (po_apx != po_exact) SHALL increment err_cnt by 1.
REQ-019 In SAMPLE, hd_sum SHALL add popcount(po_apx ^ po_exact).
REQ-020 In SAMPLE, wce SHALL take the larger of its current value and the absolute difference of po_apx and po_exact.
REQ-021 From SAMPLE:
- if pi != all-ones, pi SHALL increment and the FSM SHALL return to DRIVE;
- if pi == all-ones, the FSM SHALL go to FIN and pi SHALL hold.
REQ-022 In FIN, done SHALL be 1 for one cycle, busy SHALL drop to 0, and the FSM SHALL return to IDLE next cycle.
REQ-023 Latency: with start accepted at edge 0, done SHALL be high in cycle 2^PI_W*(SETTLE+1)+1, which is 129 for the defaults.
REQ-024 Results SHALL hold their values in IDLE until the next accepted start.
REQ-025 start SHALL be ignored while busy=1 and while in FIN.
REQ-026 abort in DRIVE or SAMPLE SHALL send the FSM to IDLE at the next edge:
- busy SHALL be 0 and done SHALL not pulse;
- accumulators SHALL hold their partial values;
- an accumulation in the same SAMPLE cycle SHALL be discarded.
REQ-027 abort and start together in IDLE SHALL start a sweep; abort in IDLE SHALL otherwise have no effect.
REQ-028 Accumulator widths SHALL be sized so that no overflow is possible; no saturation logic SHALL be present.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 With rst=1 at an edge, including mid-sweep, the following SHALL result:
- state IDLE;
- pi, err_cnt, hd_sum, wce and the settle counter all 0;
- busy=0, done=0.
REQ-031 rst SHALL take priority over start and abort.

Structure
REQ-032 Package partition_pkg SHALL hold:
- the FSM state enum;
- default PI_W/PO_W constants;
- a width function for hd_sum.
REQ-033 A single sub-module, popcount, parameterised on PO_W and purely combinational, SHALL compute the Hamming weight.

Verification
REQ-034 po_apx = po_exact = pi[3:0], defaults -> err_cnt=0, hd_sum=0, wce=0; done in cycle 129; busy high for cycles 1-128.
REQ-035 po_exact = pi[3:0], po_apx = pi[3:0] ^ 4'b0001 -> err_cnt=64, hd_sum=64, wce=1.
REQ-036 po_exact = pi[3:0], po_apx = 0 -> err_cnt=60, hd_sum=128, wce=15.
REQ-037 abort asserted in cycle 20 of the REQ-035 stimulus:
- busy drops at the next edge and done never pulses;
- the second start then clears the accumulators and reproduces the REQ-035 results.
REQ-038 rst asserted mid-sweep -> all outputs 0 next cycle; a start pulse during busy has no effect on pi sequencing or on done timing.
